led_flow: RTL and testbench

Consumer stage for the key start/done handshake. Sits directly downstream of the push-button debounce/start block: that block raises `fs` after a press-release, this block runs a one-hot running-light sequence on the LEDs, and raises `fd` when the sequence completes. The handshake is 4-phase, so one press yields exactly one sequence, and an upstream timeout aborts the sequence cleanly.

---
 rtl/led_flow.sv | 83 ++++++++
 tb/tb_led_flow.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/led_flow.sv
// rtl/led_flow.sv - one-hot running-light consumer for the 4-phase fs/fd key handshake
module led_flow #(
    parameter int LED_NUM   = 4,
    parameter int STEP_TIME = 100_000,
    parameter int ROUNDS    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fs,
    output logic               fd,
    output logic               busy,
    output logic [LED_NUM-1:0] led
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [31:0] CNT_LAST  = 32'(STEP_TIME - 1);
    localparam logic [15:0] STEP_LAST = 16'(LED_NUM * ROUNDS - 1);
    localparam logic [LED_NUM-1:0] LED_FIRST = {{(LED_NUM-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [31:0]        r_cnt;
    logic [15:0]        r_step;
    logic [LED_NUM-1:0] r_led;

    logic w_hold_end;
    assign w_hold_end = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 32'd0;
            r_step  <= 16'd0;
            r_led   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_led <= '0;
                    if (fs) begin
                        r_state <= S_RUN;
                        r_cnt   <= 32'd0;
                        r_step  <= 16'd0;
                        r_led   <= LED_FIRST;
                    end
                end
                S_RUN: begin
                    // A dropped fs is an upstream abort and wins over any step or finish.
                    if (!fs) begin
                        r_state <= S_IDLE;
                        r_led   <= '0;
                    end else if (w_hold_end && (r_step == STEP_LAST)) begin
                        r_state <= S_DONE;
                        r_led   <= '0;
                        r_cnt   <= 32'd0;
                    end else if (w_hold_end) begin
                        r_cnt  <= 32'd0;
                        r_step <= r_step + 16'd1;
                        r_led  <= {r_led[LED_NUM-2:0], r_led[LED_NUM-1]};
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    r_led <= '0;
                    if (!fs) r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_led   <= '0;
                end
            endcase
        end
    end

    assign fd   = (r_state == S_DONE);
    assign busy = (r_state == S_RUN);
    assign led  = r_led;

endmodule

// File: tb/tb_led_flow.sv
// tb/tb_led_flow.sv - randomized and directed check of led_flow against a cycle-count reference model
module tb_led_flow;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, fs_a = 1'b0;
    logic       rst_b = 1'b1, fs_b = 1'b0;
    logic       fd_a, busy_a, fd_b, busy_b;
    logic [3:0] led_a, led_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_flow #(.LED_NUM(4), .STEP_TIME(4), .ROUNDS(1)) dut_a (
        .clk(clk), .rst(rst_a), .fs(fs_a), .fd(fd_a), .busy(busy_a), .led(led_a)
    );

    led_flow #(.LED_NUM(4), .STEP_TIME(1), .ROUNDS(2)) dut_b (
        .clk(clk), .rst(rst_b), .fs(fs_b), .fd(fd_b), .busy(busy_b), .led(led_b)
    );

    // Model: mode 0 idle, 1 running, 2 done; e = cycles elapsed since the run started.
    int ma_mode = 0, ma_e = 0;
    int mb_mode = 0, mb_e = 0;

    function automatic logic [3:0] model_led(int mode, int e, int st);
        logic [3:0] v;
        v = 4'd0;
        if (mode == 1) v[(e / st) % 4] = 1'b1;
        return v;
    endfunction

    task automatic model_step(input logic r, input logic f, input int total,
                              inout int mode, inout int e);
        if (r) begin
            mode = 0; e = 0;
        end else if (mode == 0) begin
            if (f) begin mode = 1; e = 0; end
        end else if (mode == 1) begin
            if (!f) mode = 0;
            else if (e + 1 == total) mode = 2;
            else e = e + 1;
        end else begin
            if (!f) mode = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(rst_a, fs_a, 16, ma_mode, ma_e);
            model_step(rst_b, fs_b, 8, mb_mode, mb_e);
            @(negedge clk);
            chk("model_a_led",  int'(led_a),  int'(model_led(ma_mode, ma_e, 4)));
            chk("model_a_busy", int'(busy_a), int'(ma_mode == 1));
            chk("model_a_fd",   int'(fd_a),   int'(ma_mode == 2));
            chk("model_b_led",  int'(led_b),  int'(model_led(mb_mode, mb_e, 1)));
            chk("model_b_busy", int'(busy_b), int'(mb_mode == 1));
            chk("model_b_fd",   int'(fd_b),   int'(mb_mode == 2));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset and quiet idle
        tick(2);
        rst_a = 1'b0; rst_b = 1'b0;
        chk("reset_led", int'(led_a), 0);
        chk("reset_fd", int'(fd_a), 0);
        chk("reset_busy", int'(busy_a), 0);
        tick(20);
        chk("idle_led", int'(led_a), 0);

        // Normal run then re-arm
        fs_a = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("run_led", int'(led_a), 1 << ((i - 1) / 4));
            chk("run_busy", int'(busy_a), 1);
        end
        tick();
        chk("done_fd_c17", int'(fd_a), 1);
        chk("done_led_c17", int'(led_a), 0);
        tick(10);
        chk("hold_fd", int'(fd_a), 1);
        chk("hold_led", int'(led_a), 0);
        chk("hold_busy", int'(busy_a), 0);
        fs_a = 1'b0;
        tick();
        chk("fd_fall", int'(fd_a), 0);
        fs_a = 1'b1;
        tick();
        chk("rearm_led", int'(led_a), 1);

        // Abort during 0100
        tick(8);
        chk("pre_abort_led", int'(led_a), 4);
        fs_a = 1'b0;
        tick();
        chk("abort_led", int'(led_a), 0);
        chk("abort_busy", int'(busy_a), 0);
        tick(20);
        chk("abort_no_fd", int'(fd_a), 0);

        // Reset mid-run during 0010
        fs_a = 1'b1;
        tick(5);
        chk("pre_rst_led", int'(led_a), 2);
        rst_a = 1'b1;
        tick();
        chk("rst_mid_led", int'(led_a), 0);
        chk("rst_mid_busy", int'(busy_a), 0);
        rst_a = 1'b0;
        tick();
        chk("post_rst_led", int'(led_a), 1);
        fs_a = 1'b0;
        tick();

        // Wrap over two rounds, one cycle per pattern
        fs_b = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("wrap_led", int'(led_b), 1 << ((i - 1) % 4));
        end
        tick();
        chk("wrap_fd", int'(fd_b), 1);
        chk("wrap_done_led", int'(led_b), 0);
        fs_b = 1'b0;
        tick();

        // Randomized handshake traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            rst_a = ($urandom_range(0, 99) < 2);
            rst_b = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 6) fs_a = ~fs_a;
            if ($urandom_range(0, 99) < 12) fs_b = ~fs_b;
            tick();
        end
        rst_a = 1'b0; rst_b = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
